// File: rtl/exp3_condiciona_entradas.sv
// -----------------------------------------------------------------------------
// exp3_condiciona_entradas
//
// Input-conditioning stage in front of the Exp3 datapath/control pair.
// Raw board signals are brought into the clock domain through 2-FF
// synchronizers and then debounced:
//   - the push-button goes through a 4-state hysteresis FSM that emits a
//     single-cycle start pulse per accepted press;
//   - the 4 switches are qualified as a whole vector and delivered as a
//     stable value, with a one-cycle pulse whenever that value changes.
//
// Ports
//   clock               in   system clock, everything on the rising edge
//   reset               in   synchronous, active-high, clears all state
//   iniciar_bruto       in   raw push-button (asynchronous, bouncing)
//   chaves_brutas[3:0]  in   raw switches (asynchronous, bouncing)
//   iniciar_pulso       out  one-cycle pulse per accepted button press
//   chaves_estaveis[3:0]out  last debounced switch vector
//   chaves_validas      out  a first switch vector has been qualified
//   chaves_mudou        out  one-cycle pulse when chaves_estaveis changes
//   db_iniciar_filtrado out  debounced button level
//   db_estado[3:0]      out  button FSM state code (for a hexa7seg display)
// -----------------------------------------------------------------------------
module exp3_condiciona_entradas #(
  parameter int DEBOUNCE_CICLOS = 500000,
  parameter int CONT_W          = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar_bruto,
  input  logic [3:0] chaves_brutas,
  output logic       iniciar_pulso,
  output logic [3:0] chaves_estaveis,
  output logic       chaves_validas,
  output logic       chaves_mudou,
  output logic       db_iniciar_filtrado,
  output logic [3:0] db_estado
);

  localparam logic [CONT_W-1:0] LP_ULTIMO = CONT_W'(DEBOUNCE_CICLOS - 1);
  localparam logic [CONT_W-1:0] LP_UM     = CONT_W'(1);

  typedef enum logic [3:0] {
    OCIOSO         = 4'd0,
    CONFIRMA_ALTO  = 4'd1,
    ALTO           = 4'd2,
    CONFIRMA_BAIXO = 4'd3
  } estado_t;

  // Counter increment that sticks at the qualification threshold, so a
  // long-stable input never wraps around and re-triggers.
  function automatic logic [CONT_W-1:0] sat_inc(input logic [CONT_W-1:0] v);
    if (v >= LP_ULTIMO) return LP_ULTIMO;
    return v + LP_UM;
  endfunction

  // --- stage p0/p1: two-flop synchronizers --------------------------------
  logic       r_ini_sync_p0, r_ini_sync_p1;
  logic [3:0] r_chv_sync_p0, r_chv_sync_p1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ini_sync_p0 <= 1'b0;
      r_ini_sync_p1 <= 1'b0;
      r_chv_sync_p0 <= 4'h0;
      r_chv_sync_p1 <= 4'h0;
    end else begin
      r_ini_sync_p0 <= iniciar_bruto;
      r_ini_sync_p1 <= r_ini_sync_p0;
      r_chv_sync_p0 <= chaves_brutas;
      r_chv_sync_p1 <= r_chv_sync_p0;
    end
  end

  logic       w_ini_sync;
  logic [3:0] w_chv_sync;
  assign w_ini_sync = r_ini_sync_p1;
  assign w_chv_sync = r_chv_sync_p1;

  // --- stage p2: button debounce FSM --------------------------------------
  estado_t           r_estado, w_prox_estado;
  logic [CONT_W-1:0] r_cnt_b, w_prox_cnt_b;
  logic              w_pulso;
  logic              r_pulso;
  logic              r_filtrado;

  always_comb begin
    w_prox_estado = r_estado;
    w_prox_cnt_b  = r_cnt_b;
    w_pulso       = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (w_ini_sync) begin
          w_prox_estado = CONFIRMA_ALTO;
          w_prox_cnt_b  = LP_UM;
        end else begin
          w_prox_cnt_b  = '0;
        end
      end
      CONFIRMA_ALTO: begin
        if (!w_ini_sync) begin
          // glitch: drop back without a pulse
          w_prox_estado = OCIOSO;
          w_prox_cnt_b  = '0;
        end else if (r_cnt_b == LP_ULTIMO) begin
          w_prox_estado = ALTO;
          w_prox_cnt_b  = '0;
          w_pulso       = 1'b1;
        end else begin
          w_prox_cnt_b  = r_cnt_b + LP_UM;
        end
      end
      ALTO: begin
        if (!w_ini_sync) begin
          w_prox_estado = CONFIRMA_BAIXO;
          w_prox_cnt_b  = LP_UM;
        end else begin
          w_prox_cnt_b  = '0;
        end
      end
      CONFIRMA_BAIXO: begin
        if (w_ini_sync) begin
          w_prox_estado = ALTO;
          w_prox_cnt_b  = '0;
        end else if (r_cnt_b == LP_ULTIMO) begin
          w_prox_estado = OCIOSO;
          w_prox_cnt_b  = '0;
        end else begin
          w_prox_cnt_b  = r_cnt_b + LP_UM;
        end
      end
      default: begin
        // unreachable codes recover to idle
        w_prox_estado = OCIOSO;
        w_prox_cnt_b  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado   <= OCIOSO;
      r_cnt_b    <= '0;
      r_pulso    <= 1'b0;
      r_filtrado <= 1'b0;
    end else begin
      r_estado   <= w_prox_estado;
      r_cnt_b    <= w_prox_cnt_b;
      r_pulso    <= w_pulso;
      // filtered level follows the next state so it is registered, not decoded
      r_filtrado <= (w_prox_estado == ALTO) || (w_prox_estado == CONFIRMA_BAIXO);
    end
  end

  // --- stage p2: switch vector debouncer ----------------------------------
  logic [3:0]        r_cand;
  logic [CONT_W-1:0] r_cnt_c;
  logic [3:0]        r_estaveis;
  logic              r_validas;
  logic              r_mudou;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cand     <= 4'h0;
      r_cnt_c    <= '0;
      r_estaveis <= 4'h0;
      r_validas  <= 1'b0;
      r_mudou    <= 1'b0;
    end else begin
      r_mudou <= 1'b0;
      if (w_chv_sync != r_cand) begin
        // any bit moving restarts qualification of the whole vector
        r_cand  <= w_chv_sync;
        r_cnt_c <= '0;
      end else begin
        r_cnt_c <= sat_inc(r_cnt_c);
        if (r_cnt_c == LP_ULTIMO) begin
          if (!r_validas) begin
            // first qualification after reset is silent
            r_estaveis <= r_cand;
            r_validas  <= 1'b1;
          end else if (r_cand != r_estaveis) begin
            r_estaveis <= r_cand;
            r_mudou    <= 1'b1;
          end
        end
      end
    end
  end

  assign iniciar_pulso       = r_pulso;
  assign db_iniciar_filtrado = r_filtrado;
  assign db_estado           = r_estado;
  assign chaves_estaveis     = r_estaveis;
  assign chaves_validas      = r_validas;
  assign chaves_mudou        = r_mudou;

endmodule

// File: tb/tb_exp3_condiciona_entradas.sv
// -----------------------------------------------------------------------------
// tb_exp3_condiciona_entradas
//
// Bench for exp3_condiciona_entradas with DEBOUNCE_CICLOS=4, CONT_W=3.
// A reference model (sampled on every rising edge) predicts all outputs and
// pushes them into a queue; a monitor on the falling edge pops and compares.
// The model describes the behaviour as a two-edge delay, a filtered level
// that flips after D consecutive opposite samples, and a sliding window of
// the last D+1 switch samples. Directed scenarios add timing checks against
// constants.
// -----------------------------------------------------------------------------
module tb_exp3_condiciona_entradas;

  localparam int D = 4;

  logic       clock;
  logic       reset;
  logic       iniciar_bruto;
  logic [3:0] chaves_brutas;
  logic       iniciar_pulso;
  logic [3:0] chaves_estaveis;
  logic       chaves_validas;
  logic       chaves_mudou;
  logic       db_iniciar_filtrado;
  logic [3:0] db_estado;

  exp3_condiciona_entradas #(
    .DEBOUNCE_CICLOS(D),
    .CONT_W(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .iniciar_bruto(iniciar_bruto),
    .chaves_brutas(chaves_brutas),
    .iniciar_pulso(iniciar_pulso),
    .chaves_estaveis(chaves_estaveis),
    .chaves_validas(chaves_validas),
    .chaves_mudou(chaves_mudou),
    .db_iniciar_filtrado(db_iniciar_filtrado),
    .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_pulsos = 0;
  int n_mudou  = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic       pulso;
    logic [3:0] estaveis;
    logic       validas;
    logic       mudou;
    logic       filt;
    logic [3:0] estado;
  } saida_t;

  saida_t exp_q[$];

  // ---------------- reference model ----------------
  logic       m_s1_b, m_s2_b, m_visto_b;
  logic [3:0] m_s1_c, m_s2_c, m_visto_c;
  logic       m_nivel;
  int         m_corrida;
  logic [3:0] m_janela[$];
  logic [3:0] m_estaveis;
  logic       m_validas, m_pulso, m_mudou, m_todos;
  saida_t     m_e;

  always @(posedge clock) begin
    if (reset) begin
      m_s1_b = 1'b0; m_s2_b = 1'b0;
      m_s1_c = 4'h0; m_s2_c = 4'h0;
      m_nivel = 1'b0; m_corrida = 0;
      m_janela = {4'h0};
      m_estaveis = 4'h0; m_validas = 1'b0;
      m_pulso = 1'b0; m_mudou = 1'b0;
    end else begin
      m_visto_b = m_s2_b; m_s2_b = m_s1_b; m_s1_b = iniciar_bruto;
      m_visto_c = m_s2_c; m_s2_c = m_s1_c; m_s1_c = chaves_brutas;
      // button: level flips after D consecutive samples disagreeing with it
      m_pulso = 1'b0;
      if (m_visto_b != m_nivel) begin
        m_corrida = m_corrida + 1;
        if (m_corrida == D) begin
          m_nivel   = ~m_nivel;
          m_corrida = 0;
          m_pulso   = m_nivel;
        end
      end else begin
        m_corrida = 0;
      end
      // switches: accept when the last D+1 samples all agree
      m_mudou = 1'b0;
      m_janela.push_back(m_visto_c);
      if (m_janela.size() > D + 1) void'(m_janela.pop_front());
      if (m_janela.size() == D + 1) begin
        m_todos = 1'b1;
        foreach (m_janela[i]) if (m_janela[i] != m_janela[0]) m_todos = 1'b0;
        if (m_todos) begin
          if (!m_validas) begin
            m_validas  = 1'b1;
            m_estaveis = m_janela[0];
          end else if (m_janela[0] != m_estaveis) begin
            m_estaveis = m_janela[0];
            m_mudou    = 1'b1;
          end
        end
      end
    end
    m_e.pulso    = m_pulso;
    m_e.estaveis = m_estaveis;
    m_e.validas  = m_validas;
    m_e.mudou    = m_mudou;
    m_e.filt     = m_nivel;
    m_e.estado   = {2'b00, m_nivel, (m_corrida != 0)};
    exp_q.push_back(m_e);
  end

  // ---------------- monitor ----------------
  saida_t mon_esp, mon_got;
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_esp = exp_q.pop_front();
      mon_got.pulso    = iniciar_pulso;
      mon_got.estaveis = chaves_estaveis;
      mon_got.validas  = chaves_validas;
      mon_got.mudou    = chaves_mudou;
      mon_got.filt     = db_iniciar_filtrado;
      mon_got.estado   = db_estado;
      checks = checks + 1;
      if (mon_got !== mon_esp) begin
        errors = errors + 1;
        $display("FAIL saidas cyc=%0d got pulso=%b est=%h val=%b mud=%b filt=%b estado=%0d exp pulso=%b est=%h val=%b mud=%b filt=%b estado=%0d",
                 cyc, mon_got.pulso, mon_got.estaveis, mon_got.validas, mon_got.mudou,
                 mon_got.filt, mon_got.estado, mon_esp.pulso, mon_esp.estaveis,
                 mon_esp.validas, mon_esp.mudou, mon_esp.filt, mon_esp.estado);
      end
    end
    if (iniciar_pulso === 1'b1) n_pulsos = n_pulsos + 1;
    if (chaves_mudou === 1'b1)  n_mudou  = n_mudou + 1;
  end

  // ---------------- helpers ----------------
  task automatic verifica(input string nome, input int got, input int esp);
    checks = checks + 1;
    if (got != esp) begin
      errors = errors + 1;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nome, cyc, got, esp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic verifica_zeros(input string nome);
    verifica({nome, "_pulso"},    int'(iniciar_pulso), 0);
    verifica({nome, "_estaveis"}, int'(chaves_estaveis), 0);
    verifica({nome, "_validas"},  int'(chaves_validas), 0);
    verifica({nome, "_mudou"},    int'(chaves_mudou), 0);
    verifica({nome, "_filt"},     int'(db_iniciar_filtrado), 0);
    verifica({nome, "_estado"},   int'(db_estado), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  int p0, q0, r0;

  initial begin
    reset = 1'b1;
    iniciar_bruto = 1'b1;
    chaves_brutas = 4'hF;

    // reset held 3 edges with every raw input high
    for (int i = 0; i < 3; i++) begin
      tick(1);
      verifica_zeros("reset_alto");
    end
    #1 reset = 1'b0; r0 = cyc; p0 = n_pulsos;
    tick(5);
    verifica("pos_reset_sem_pulso", int'(iniciar_pulso), 0);
    tick(1);
    verifica("pos_reset_pulso", int'(iniciar_pulso), 1);
    verifica("pos_reset_lat", cyc - r0, 6);
    tick(1);
    verifica("pos_reset_pulso_fim", int'(iniciar_pulso), 0);
    tick(10);
    #1;
    verifica("pos_reset_n_pulsos", n_pulsos - p0, 1);
    verifica("pos_reset_validas", int'(chaves_validas), 1);
    verifica("pos_reset_estaveis", int'(chaves_estaveis), 15);
    verifica("pos_reset_sem_mudou", n_mudou, 0);

    // clean press and release
    iniciar_bruto = 1'b0;
    tick(10);
    #1 p0 = n_pulsos; r0 = cyc; iniciar_bruto = 1'b1;
    tick(2);
    verifica("press_estado0", int'(db_estado), 0);
    tick(1);
    verifica("press_estado1", int'(db_estado), 1);
    tick(2);
    verifica("press_sem_pulso_cedo", int'(iniciar_pulso), 0);
    tick(1);
    verifica("press_pulso", int'(iniciar_pulso), 1);
    verifica("press_estado2", int'(db_estado), 2);
    tick(1);
    verifica("press_pulso_unico", int'(iniciar_pulso), 0);
    tick(13);
    #1;
    verifica("press_n_pulsos", n_pulsos - p0, 1);
    iniciar_bruto = 1'b0;
    tick(5);
    verifica("solta_filt_ainda", int'(db_iniciar_filtrado), 1);
    tick(1);
    verifica("solta_filt_cai", int'(db_iniciar_filtrado), 0);
    verifica("solta_estado0", int'(db_estado), 0);

    // bouncing press never qualifies
    tick(5);
    #1 p0 = n_pulsos;
    iniciar_bruto = 1'b1; tick(1);
    #1 iniciar_bruto = 1'b0; tick(1);
    #1 iniciar_bruto = 1'b1; tick(1);
    #1 iniciar_bruto = 1'b1; tick(1);
    #1 iniciar_bruto = 1'b0;
    tick(10);
    #1;
    verifica("quique_sem_pulso", n_pulsos - p0, 0);
    verifica("quique_estado0", int'(db_estado), 0);

    // release bounce while held returns to ALTO without re-pulse
    iniciar_bruto = 1'b1;
    tick(12);
    #1 iniciar_bruto = 1'b0; tick(1);
    #1 iniciar_bruto = 1'b1;
    tick(10);
    #1;
    verifica("quique_solta_n_pulsos", n_pulsos - p0, 1);
    verifica("quique_solta_estado2", int'(db_estado), 2);
    iniciar_bruto = 1'b0;
    tick(10);

    // switches: qualify 3, then toggling A/B, then stable A
    #1 chaves_brutas = 4'h3;
    tick(12);
    verifica("chv_3", int'(chaves_estaveis), 3);
    #1 q0 = n_mudou;
    for (int i = 0; i < 4; i++) begin
      chaves_brutas = (i % 2 == 1) ? 4'hB : 4'hA;
      tick(2);
      verifica("chv_toggle_mantem", int'(chaves_estaveis), 3);
      #1;
    end
    chaves_brutas = 4'hA;
    tick(12);
    #1;
    verifica("chv_A", int'(chaves_estaveis), 10);
    verifica("chv_A_um_mudou", n_mudou - q0, 1);

    // short excursion 3 -> 5 -> 3
    chaves_brutas = 4'h3;
    tick(12);
    #1 q0 = n_mudou; chaves_brutas = 4'h5;
    tick(2);
    verifica("chv_5_curto", int'(chaves_estaveis), 3);
    #1 chaves_brutas = 4'h3;
    tick(12);
    #1;
    verifica("chv_volta_3", int'(chaves_estaveis), 3);
    verifica("chv_volta_sem_mudou", n_mudou - q0, 0);

    // reset mid-confirmation with switches mid-qualification
    chaves_brutas = 4'hC; iniciar_bruto = 1'b1;
    tick(3);
    verifica("meio_estado1", int'(db_estado), 1);
    #1 reset = 1'b1;
    tick(1);
    verifica_zeros("meio_reset");
    #1 reset = 1'b0; r0 = cyc;
    tick(5);
    verifica("meio_sem_pulso", int'(iniciar_pulso), 0);
    tick(1);
    verifica("meio_pulso", int'(iniciar_pulso), 1);
    tick(1);
    verifica("meio_pulso_fim", int'(iniciar_pulso), 0);
    verifica("meio_validas_novo", int'(chaves_validas), 1);
    tick(5);
    verifica("meio_estaveis", int'(chaves_estaveis), 12);

    // randomized traffic, checked by the scoreboard
    for (int i = 0; i < 3000; i++) begin
      #1;
      if ($urandom_range(0, 5) == 0) iniciar_bruto = ~iniciar_bruto;
      if ($urandom_range(0, 7) == 0) chaves_brutas = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    #1 reset = 1'b0;
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
